mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Memory interface stage directly downstream of the effective-address adder and MARMUX in the LC-3 datapath.
- Holds MAR and MDR, and sequences one memory read or write per request using a req/ack handshake. Produces the LC-3 "R" (memory ready) signal for the control FSM.
- Adds a wait-state timeout so a dead memory port cannot hang the control FSM.

Parameters:
- AW, 16, address width (MAR).
- DW, 16, data width (MDR).
- TIMEOUT, 255, maximum cycles in ACCESS without ack before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ld_mar  in  1  load MAR from mar_in.
- mar_in  in  AW  effective address from MARMUX (adder sum or zext trapvect8).
- ld_mdr  in  1  load MDR from bus_in; CPU side, used for stores.
- bus_in  in  DW  datapath bus value.
- mem_en  in  1  start an access; single-cycle pulse from the control FSM.
- mem_we  in  1  sampled with mem_en: 1 = write, 0 = read.
- mar_out  out  AW  current MAR.
- mdr_out  out  DW  current MDR (drives GateMDR).
- mem_req  out  1  memory request, held until ack or timeout.
- mem_wr  out  1  write qualifier, valid while mem_req is high.
- mem_addr  out  AW  address captured at start, stable during the request.
- mem_wdata  out  DW  MDR captured at start, stable during the request.
- mem_rdata  in  DW  read data, valid with mem_ack.
- mem_ack  in  1  memory completion.
- ready  out  1  one-cycle pulse when an access finishes (LC-3 R).
- busy  out  1  high in ACCESS.
- err_timeout  out  1  one-cycle pulse, coincident with ready, when an access aborted.

Behaviour:
- Reset: all of the following are 0 and the FSM is in IDLE:
  - mar_out, mdr_out, mem_addr, mem_wdata
  - mem_req, mem_wr, ready, busy, err_timeout
  - the timeout counter
- Reset asserted mid-access aborts the access immediately. No ready pulse is produced.
- FSM has two states, IDLE and ACCESS.
- IDLE:
  - ld_mar loads MAR; ld_mdr loads MDR.
  - On mem_en, capture mem_addr and mem_wdata and set mem_wr = mem_we. Assert mem_req and busy on the next cycle, go to ACCESS, clear the counter.
  - If ld_mar and mem_en coincide, MAR and mem_addr both take mar_in.
  - If ld_mdr and mem_en coincide, MDR and mem_wdata both take bus_in.
- ACCESS:
  - mem_req stays high and the counter increments each cycle.
  - On the edge where mem_req and mem_ack are both high:
    - drop mem_req, mem_wr and busy;
    - pulse ready for one cycle;
    - on a read, load MDR with mem_rdata (visible together with ready);
    - return to IDLE.
  - If the counter reaches TIMEOUT (TIMEOUT ≠ 0) without ack:
    - drop mem_req;
    - pulse ready and err_timeout together;
    - on a read, load MDR with all ones (16'hFFFF);
    - return to IDLE.
  - If ack arrives in the same cycle the counter hits TIMEOUT, ack wins and no error is flagged.
- Latency: mem_en in cycle 0 gives mem_req in cycle 1. Ack in cycle k (k ≥ 1) gives ready in cycle k+1. With a zero-wait memory (ack in cycle 1), ready arrives in cycle 2.
- While busy, ld_mar, ld_mdr and mem_en are ignored; MAR and MDR hold their values.
- mem_ack while not requesting is ignored. Back-to-back: mem_en in the cycle ready is high is accepted, since the FSM is already IDLE.
- No arithmetic. The counter is an 8-bit unsigned register (width sized for TIMEOUT) and saturates, never wraps.

Decomposition:
- Shared package lc3_pkg holds:
  - state enum {IDLE, ACCESS};
  - DW/AW defaults (16);
  - constant MDR_ERR_VAL = 16'hFFFF.
- One natural sub-module: access_timer (loadable saturating counter with a terminal flag). Instantiate it once.

Test Plan:
- Zero-wait read: ld_mar with mar_in = 16'h3000; mem_en, mem_we = 0; memory acks in cycle 1 with 16'hBEEF -> mem_addr = 16'h3000, ready in cycle 2, mdr_out = 16'hBEEF.
- Write with 3 wait states: ld_mdr with bus_in = 16'h1234, mar_in = 16'hFE06, mem_en, mem_we = 1, ack in cycle 4 -> mem_wr = 1 and mem_wdata = 16'h1234 during cycles 1–4, ready in cycle 5, MDR unchanged.
- Timeout: TIMEOUT = 4, read with no ack -> mem_req high for cycles 1–4, ready and err_timeout in cycle 5, mdr_out = 16'hFFFF.
- Busy lockout: during a pending read, pulse ld_mar with 16'h0000 and mem_en -> mar_out and mem_addr unchanged, and only one ready pulse occurs.
- Reset mid-access: assert rst_n low in cycle 2 of a read -> mem_req, busy and mdr_out go to 0 asynchronously. A later ack produces no ready.
- Coincident ack and timeout: TIMEOUT = 3, ack in cycle 3 with 16'h00AA -> ready, err_timeout = 0, mdr_out = 16'h00AA.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared LC-3 memory-stage types and constants.
// Imported by the memory access controller, its bus interface and its timer.
package lc3_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_e;

   localparam int unsigned AW_DEF = 16;
   localparam int unsigned DW_DEF = 16;
   localparam int unsigned TMR_W  = 8;

   localparam logic [15:0] MDR_ERR_VAL = 16'hFFFF;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/acknowledge memory port between the LC-3 memory stage and the memory.
// The master side issues requests; the slave side completes them.
interface mem_access_ctrl_if
   import lc3_pkg::*;
#(
   parameter int unsigned AW = AW_DEF,
   parameter int unsigned DW = DW_DEF
);
   logic          mem_req;
   logic          mem_wr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;

   modport master (
      output mem_req, mem_wr, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_wr, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/access_timer.sv
// Wait-state counter: clears on request start, counts while an access is pending,
// saturates at all ones and flags the cycle in which the next edge reaches TIMEOUT.
module access_timer
   import lc3_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic done_o
);
   localparam bit               ENABLED = (TIMEOUT != 0);
   localparam logic [TMR_W-1:0] TERM    = TMR_W'(TIMEOUT - 1);

   logic [TMR_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + TMR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Abort is decided on the edge that would take the count to TIMEOUT.
   assign done_o = ENABLED && (cnt_q == TERM);

endmodule

// File: rtl/mem_access_ctrl.sv
// LC-3 memory stage: owns MAR/MDR, runs one read or write per mem_en over a
// req/ack port, reports completion as the R pulse and aborts stalled accesses.
module mem_access_ctrl
   import lc3_pkg::*;
#(
   parameter int unsigned AW      = AW_DEF,
   parameter int unsigned DW      = DW_DEF,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ld_mar,
   input  logic [AW-1:0] mar_in,
   input  logic          ld_mdr,
   input  logic [DW-1:0] bus_in,
   input  logic          mem_en,
   input  logic          mem_we,
   output logic [AW-1:0] mar_out,
   output logic [DW-1:0] mdr_out,
   mem_access_ctrl_if.master mem,
   output logic          ready,
   output logic          busy,
   output logic          err_timeout
);
   state_e        state_q, state_d;
   logic [AW-1:0] mar_q, mar_d, addr_q, addr_d;
   logic [DW-1:0] mdr_q, mdr_d, wdata_q, wdata_d;
   logic          wr_q, wr_d, ready_q, ready_d, err_q, err_d;
   logic          tmr_clr, tmr_en, tmr_done;

   access_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (tmr_clr),
      .en_i   (tmr_en),
      .done_o (tmr_done)
   );

   always_comb begin
      // NOTE: every _d gets a default first, so no path through the case can infer a latch.
      state_d = state_q;
      mar_d   = mar_q;
      mdr_d   = mdr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wr_d    = wr_q;
      ready_d = 1'b0;
      err_d   = 1'b0;
      tmr_clr = 1'b0;
      tmr_en  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (ld_mar) mar_d = mar_in;
            if (ld_mdr) mdr_d = bus_in;
            if (mem_en) begin
               // A load coinciding with mem_en reaches the request as well.
               addr_d  = mar_d;
               wdata_d = mdr_d;
               wr_d    = mem_we;
               tmr_clr = 1'b1;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            tmr_en = 1'b1;
            if (mem.mem_ack) begin
               state_d = IDLE;
               wr_d    = 1'b0;
               ready_d = 1'b1;
               if (!wr_q) mdr_d = mem.mem_rdata;
            end else if (tmr_done) begin
               state_d = IDLE;
               wr_d    = 1'b0;
               ready_d = 1'b1;
               err_d   = 1'b1;
               if (!wr_q) mdr_d = DW'(MDR_ERR_VAL);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mar_q   <= '0;
         mdr_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values regardless of order.
         state_q <= state_d;
         mar_q   <= mar_d;
         mdr_q   <= mdr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
         ready_q <= ready_d;
         err_q   <= err_d;
      end
   end

   assign mem.mem_req   = (state_q == ACCESS);
   assign mem.mem_wr    = wr_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;
   assign busy          = (state_q == ACCESS);
   assign mar_out       = mar_q;
   assign mdr_out       = mdr_q;
   assign ready         = ready_q;
   assign err_timeout   = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Drives three controllers (TIMEOUT 4, 3 and disabled) with identical stimulus and
// checks each against a transaction-level model of request length, R pulse and MAR/MDR.
module tb_mem_access_ctrl;

   function automatic int unsigned timeout_of(input int g);
      return (g == 0) ? 4 : (g == 1) ? 3 : 0;
   endfunction

   logic        clk;
   logic        rst_n;
   logic        ld_mar, ld_mdr, mem_en, mem_we, mem_ack;
   logic [15:0] mar_in, bus_in, mem_rdata;

   logic [2:0]  req_v, wr_v, ready_v, busy_v, err_v;
   logic [15:0] mar_v [3];
   logic [15:0] mdr_v [3];
   logic [15:0] addr_v [3];
   logic [15:0] wdata_v [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mem_access_ctrl_if #(.AW(16), .DW(16)) bus ();
      logic [15:0] mar_o, mdr_o;
      logic        ready_o, busy_o, err_o;

      assign bus.mem_rdata = mem_rdata;
      assign bus.mem_ack   = mem_ack;

      mem_access_ctrl #(.AW(16), .DW(16), .TIMEOUT(timeout_of(g))) dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .ld_mar      (ld_mar),
         .mar_in      (mar_in),
         .ld_mdr      (ld_mdr),
         .bus_in      (bus_in),
         .mem_en      (mem_en),
         .mem_we      (mem_we),
         .mar_out     (mar_o),
         .mdr_out     (mdr_o),
         .mem         (bus.master),
         .ready       (ready_o),
         .busy        (busy_o),
         .err_timeout (err_o)
      );

      assign req_v[g]   = bus.mem_req;
      assign wr_v[g]    = bus.mem_wr;
      assign ready_v[g] = ready_o;
      assign busy_v[g]  = busy_o;
      assign err_v[g]   = err_o;
      assign mar_v[g]   = mar_o;
      assign mdr_v[g]   = mdr_o;
      assign addr_v[g]  = bus.mem_addr;
      assign wdata_v[g] = bus.mem_wdata;
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   logic [15:0] mar_m;
   logic [15:0] mdr_m [3];

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // {req, busy, wr while requesting, ready, err_timeout}
   function automatic logic [15:0] obs_status(input int g);
      return {11'b0, req_v[g], busy_v[g], req_v[g] & wr_v[g], ready_v[g], err_v[g]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_quiet();
      ld_mar    = 1'b0;
      ld_mdr    = 1'b0;
      mem_en    = 1'b0;
      mem_ack   = 1'b0;
      mar_in    = 16'($urandom);
      bus_in    = 16'($urandom);
      mem_rdata = 16'($urandom);
   endtask

   // Idle cycle: registers must match the model, loads may be applied, a stray ack is sent.
   task automatic idle_cycle(input bit do_mar, input logic [15:0] a,
                             input bit do_mdr, input logic [15:0] d);
      step();
      for (int g = 0; g < 3; g++) begin
         check($sformatf("idle_status[%0d]", g), obs_status(g), 16'h0);
         check($sformatf("idle_mar[%0d]", g), mar_v[g], mar_m);
         check($sformatf("idle_mdr[%0d]", g), mdr_v[g], mdr_m[g]);
      end
      drive_quiet();
      ld_mar  = do_mar;
      mar_in  = a;
      ld_mdr  = do_mdr;
      bus_in  = d;
      mem_ack = 1'b1;
      if (do_mar) mar_m = a;
      for (int g = 0; g < 3; g++) if (do_mdr) mdr_m[g] = d;
   endtask

   // One access issued in cycle 0, memory acks in cycle k. Returns in the last R cycle.
   task automatic run_txn(input logic [15:0] addr, input logic [15:0] data,
                          input logic [15:0] rdata, input bit we, input bit use_mar,
                          input bit use_mdr, input bit noise, input int k, input bit chain);
      int          end_c [3];
      bit          to [3];
      int          last;
      logic [15:0] exp_addr;
      logic [15:0] exp_wd [3];
      logic [15:0] exp_st;

      if (!chain) step();
      drive_quiet();
      ld_mar = use_mar;
      mar_in = addr;
      ld_mdr = use_mdr;
      bus_in = data;
      mem_en = 1'b1;
      mem_we = we;

      if (use_mar) mar_m = addr;
      exp_addr = mar_m;
      last = 0;
      for (int g = 0; g < 3; g++) begin
         if (use_mdr) mdr_m[g] = data;
         exp_wd[g] = mdr_m[g];
         to[g]     = (timeout_of(g) != 0) && (timeout_of(g) < k);
         end_c[g]  = to[g] ? int'(timeout_of(g)) : k;
         if (end_c[g] > last) last = end_c[g];
      end

      for (int cyc = 1; cyc <= last + 1; cyc++) begin
         step();
         drive_quiet();
         if (noise && cyc == 1) begin
            ld_mar = 1'b1;
            mar_in = 16'h0000;
            ld_mdr = 1'b1;
            mem_en = 1'b1;
            mem_we = !we;
         end
         if (cyc == k) begin
            mem_ack   = 1'b1;
            mem_rdata = rdata;
         end
         for (int g = 0; g < 3; g++) begin
            if (cyc <= end_c[g])          exp_st = {11'b0, 1'b1, 1'b1, we, 1'b0, 1'b0};
            else if (cyc == end_c[g] + 1) exp_st = {11'b0, 3'b000, 1'b1, to[g]};
            else                          exp_st = 16'h0;
            check($sformatf("status[%0d] c%0d", g, cyc), obs_status(g), exp_st);
            if (cyc == 1 || cyc == end_c[g]) begin
               check($sformatf("mem_addr[%0d] c%0d", g, cyc), addr_v[g], exp_addr);
               check($sformatf("mem_wdata[%0d] c%0d", g, cyc), wdata_v[g], exp_wd[g]);
            end
            if (cyc == end_c[g] + 1) begin
               if (!we) mdr_m[g] = to[g] ? 16'hFFFF : rdata;
               check($sformatf("mar_out[%0d] done", g), mar_v[g], mar_m);
               check($sformatf("mdr_out[%0d] done", g), mdr_v[g], mdr_m[g]);
            end
         end
      end
   endtask

   task automatic reset_check(input string tag);
      for (int g = 0; g < 3; g++) begin
         check($sformatf("%s_status[%0d]", tag, g), obs_status(g), 16'h0);
         check($sformatf("%s_mar[%0d]", tag, g), mar_v[g], 16'h0);
         check($sformatf("%s_mdr[%0d]", tag, g), mdr_v[g], 16'h0);
         check($sformatf("%s_addr[%0d]", tag, g), addr_v[g], 16'h0);
         check($sformatf("%s_wdata[%0d]", tag, g), wdata_v[g], 16'h0);
      end
      mar_m = 16'h0;
      for (int g = 0; g < 3; g++) mdr_m[g] = 16'h0;
   endtask

   task automatic mid_access_reset();
      step();
      drive_quiet();
      ld_mar = 1'b1;
      mar_in = 16'h4444;
      ld_mdr = 1'b1;
      bus_in = 16'h5555;
      mem_en = 1'b1;
      mem_we = 1'b0;
      step();
      drive_quiet();
      step();
      drive_quiet();
      for (int g = 0; g < 3; g++)
         check($sformatf("pre_rst_status[%0d]", g), obs_status(g), 16'h0018);
      #2 rst_n = 1'b0;
      #1 reset_check("mid_rst");
      @(negedge clk) rst_n = 1'b1;
      step();
      drive_quiet();
      mem_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         drive_quiet();
         for (int g = 0; g < 3; g++)
            check($sformatf("post_rst_status[%0d] c%0d", g, i), obs_status(g), 16'h0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n  = 1'b0;
      mem_we = 1'b0;
      drive_quiet();
      #3 reset_check("por");
      @(negedge clk) rst_n = 1'b1;

      // Zero-wait read.
      run_txn(16'h3000, 16'h0000, 16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0);
      // Write with three wait states (TIMEOUT 3 aborts it; TIMEOUT 4 sees ack on its last cycle).
      run_txn(16'hFE06, 16'h1234, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 4, 1'b0);
      idle_cycle(1'b0, 16'h0, 1'b0, 16'h0);
      // Read with no ack inside the TIMEOUT window.
      run_txn(16'h0123, 16'h0000, 16'h7777, 1'b0, 1'b1, 1'b0, 1'b0, 6, 1'b0);
      // Ack on the cycle the TIMEOUT 3 counter expires.
      run_txn(16'h0456, 16'h0000, 16'h00AA, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b0);
      // Loads and mem_en while busy are ignored.
      run_txn(16'h2222, 16'h0000, 16'h5A5A, 1'b0, 1'b1, 1'b0, 1'b1, 3, 1'b0);
      // Back-to-back: next mem_en in the R cycle.
      run_txn(16'h1000, 16'h9999, 16'hC0DE, 1'b1, 1'b1, 1'b1, 1'b0, 1, 1'b0);
      run_txn(16'h1001, 16'h0000, 16'hD00D, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b1);
      idle_cycle(1'b0, 16'h0, 1'b0, 16'h0);

      mid_access_reset();

      for (int n = 0; n < 60; n++) begin
         bit chain;
         chain = ($urandom_range(0, 3) == 0);
         if (!chain)
            idle_cycle(1'($urandom), 16'($urandom), 1'($urandom), 16'($urandom));
         run_txn(16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(1, 7), chain);
      end
      idle_cycle(1'b0, 16'h0, 1'b0, 16'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
